// File: rtl/linked_list_mq_fifo_if.sv
// Bus bundle for linked_list_mq_fifo: enqueue, dequeue and flush requests, plus
// popped data and the per-queue status returned by the buffer.
interface linked_list_mq_fifo_if #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
);
  logic                                 push;
  logic [SEL_WIDTH-1:0]                 push_sel;
  logic [WIDTH-1:0]                     data_in;
  logic                                 pop;
  logic [SEL_WIDTH-1:0]                 pop_sel;
  logic                                 flush;
  logic [SEL_WIDTH-1:0]                 flush_sel;
  logic [WIDTH-1:0]                     data_out;
  logic                                 data_out_vld;
  logic [NUM_FIFOS-1:0]                 empty;
  logic                                 full;
  logic [NUM_FIFOS-1:0]                 can_push;
  logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]   count;
  logic [PTR_WIDTH:0]                   free_count;
  logic                                 overflow;
  logic                                 underflow;

  modport master (
    output push, push_sel, data_in, pop, pop_sel, flush, flush_sel,
    input  data_out, data_out_vld, empty, full, can_push, count, free_count,
           overflow, underflow
  );

  modport slave (
    input  push, push_sel, data_in, pop, pop_sel, flush, flush_sel,
    output data_out, data_out_vld, empty, full, can_push, count, free_count,
           overflow, underflow
  );
endinterface

// File: rtl/linked_list_mq_fifo.sv
// Multi-queue FIFO sharing one entry store through next-pointer linked lists,
// with per-queue reserved capacity, single-cycle queue flush and sticky error flags.
module linked_list_mq_fifo #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int RESERVE   = 0,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  linked_list_mq_fifo_if.slave   bus
);

  localparam int CW = PTR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [CW-1:0]        cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             nxt_q [DEPTH];
  ptr_t             nxt_d [DEPTH];

  ptr_t head_q [NUM_FIFOS];
  ptr_t head_d [NUM_FIFOS];
  ptr_t tail_q [NUM_FIFOS];
  ptr_t tail_d [NUM_FIFOS];
  cnt_t cnt_q  [NUM_FIFOS];
  cnt_t cnt_d  [NUM_FIFOS];

  ptr_t freeHead_q, freeHead_d;
  ptr_t freeTail_q, freeTail_d;
  cnt_t freeCount_q, freeCount_d;

  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic             dataVld_q, dataVld_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [NUM_FIFOS-1:0] canPush;
  int                   deficit;

  logic pushSelOk, popSelOk, flushReq;
  logic pushBlocked, popBlocked;
  logic pushOk, popOk, flushOk;
  ptr_t allocPtr, popPtr;
  ptr_t flushHead, flushTail;
  cnt_t flushCount;

  // Admission: queues below their reserve may take any free entry; others must
  // leave enough free entries to cover every queue's outstanding reserve.
  always_comb begin
    deficit = 0;
    canPush = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      if (int'(cnt_q[q]) < RESERVE) begin
        deficit = deficit + (RESERVE - int'(cnt_q[q]));
      end
    end
    for (int q = 0; q < NUM_FIFOS; q++) begin
      if (int'(cnt_q[q]) < RESERVE) begin
        canPush[q] = (freeCount_q != '0);
      end else begin
        canPush[q] = (int'(freeCount_q) > deficit);
      end
    end
  end

  always_comb begin
    pushSelOk   = (int'(bus.push_sel) < NUM_FIFOS);
    popSelOk    = (int'(bus.pop_sel) < NUM_FIFOS);
    flushReq    = bus.flush && (int'(bus.flush_sel) < NUM_FIFOS);
    pushBlocked = flushReq && (bus.flush_sel == bus.push_sel);
    popBlocked  = flushReq && (bus.flush_sel == bus.pop_sel);
    pushOk      = bus.push && !pushBlocked && pushSelOk && canPush[bus.push_sel];
    popOk       = bus.pop && !popBlocked && popSelOk && (cnt_q[bus.pop_sel] != '0);
    flushOk     = flushReq && (cnt_q[bus.flush_sel] != '0);
    allocPtr    = freeHead_q;
    popPtr      = head_q[bus.pop_sel];
    flushHead   = head_q[bus.flush_sel];
    flushTail   = tail_q[bus.flush_sel];
    flushCount  = cnt_q[bus.flush_sel];
  end

  // Next state: queue lists first, then the free list in the order
  // allocate-from-head, append popped entry, append flushed chain.
  always_comb begin
    nxt_d       = nxt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    freeHead_d  = freeHead_q;
    freeTail_d  = freeTail_q;
    freeCount_d = freeCount_q;
    dataOut_d   = dataOut_q;
    dataVld_d   = popOk;
    overflow_d  = overflow_q | (bus.push && !pushBlocked && !pushOk);
    underflow_d = underflow_q | (bus.pop && !popBlocked && !popOk);

    if (popOk) begin
      dataOut_d = mem_q[popPtr];
    end

    for (int q = 0; q < NUM_FIFOS; q++) begin
      if (flushOk && (bus.flush_sel == SEL_WIDTH'(q))) begin
        cnt_d[q] = '0;
      end else begin
        if (popOk && (bus.pop_sel == SEL_WIDTH'(q))) begin
          head_d[q] = nxt_q[head_q[q]];
          cnt_d[q]  = cnt_d[q] - cnt_t'(1);
        end
        if (pushOk && (bus.push_sel == SEL_WIDTH'(q))) begin
          if (cnt_d[q] == '0) begin
            head_d[q] = allocPtr;
          end else begin
            nxt_d[tail_q[q]] = allocPtr;
          end
          tail_d[q] = allocPtr;
          cnt_d[q]  = cnt_d[q] + cnt_t'(1);
        end
      end
    end

    if (pushOk) begin
      freeHead_d  = nxt_q[freeHead_q];
      freeCount_d = freeCount_q - cnt_t'(1);
    end

    if (popOk) begin
      if (freeCount_d == '0) begin
        freeHead_d = popPtr;
      end else begin
        nxt_d[freeTail_q] = popPtr;
      end
      freeTail_d  = popPtr;
      freeCount_d = freeCount_d + cnt_t'(1);
    end

    if (flushOk) begin
      if (freeCount_d == '0) begin
        freeHead_d = flushHead;
      end else begin
        nxt_d[freeTail_d] = flushHead;
      end
      freeTail_d  = flushTail;
      freeCount_d = freeCount_d + flushCount;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        nxt_q[i] <= ptr_t'((i + 1) % DEPTH);
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        cnt_q[q]  <= '0;
      end
      freeHead_q  <= '0;
      freeTail_q  <= ptr_t'(DEPTH - 1);
      freeCount_q <= cnt_t'(DEPTH);
      dataOut_q   <= '0;
      dataVld_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      nxt_q       <= nxt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      freeHead_q  <= freeHead_d;
      freeTail_q  <= freeTail_d;
      freeCount_q <= freeCount_d;
      dataOut_q   <= dataOut_d;
      dataVld_q   <= dataVld_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The data store needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (rst && pushOk) begin
      mem_q[allocPtr] <= bus.data_in;
    end
  end

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_status
    assign bus.empty[g]              = (cnt_q[g] == '0);
    assign bus.count[g*CW +: CW]     = cnt_q[g];
  end

  assign bus.can_push     = canPush;
  assign bus.full         = (freeCount_q == '0);
  assign bus.free_count   = freeCount_q;
  assign bus.data_out     = dataOut_q;
  assign bus.data_out_vld = dataVld_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/linked_list_mq_fifo.md
# linked_list_mq_fifo

Multi-queue shared-buffer FIFO: `NUM_FIFOS` logical queues share one `DEPTH`-entry data store, with next-pointer linked lists for each queue and for the free list. This block extends the existing linked-list shared FIFO with per-queue reserved capacity, a single-cycle whole-queue flush, and registered pop data with a valid strobe. It records illegal push and pop requests in sticky flags instead of relying on environment constraints. It is the buffer stage in front of the per-channel arbiters and is the next target for the refinement proof.

## Interface
- `WIDTH`, 4, data bits per entry.
- `DEPTH`, 4, shared entries; power of two, at least 2.
- `NUM_FIFOS`, 2, logical queues; at least 1.
- `RESERVE`, 0, entries guaranteed per queue; `NUM_FIFOS*RESERVE <= DEPTH`.
- `PTR_WIDTH`, `$clog2(DEPTH)`, entry pointer width.
- `SEL_WIDTH`, `max(1,$clog2(NUM_FIFOS))`, queue select width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` at a rising edge resets the block).
- `push` in 1, `push_sel` in SEL_WIDTH, `data_in` in WIDTH: enqueue request.
- `pop` in 1, `pop_sel` in SEL_WIDTH: dequeue request.
- `flush` in 1, `flush_sel` in SEL_WIDTH: discard an entire queue.
- `data_out` out WIDTH, `data_out_vld` out 1: popped data (registered).
- `empty` out NUM_FIFOS: per-queue empty.
- `full` out 1: free list empty.
- `can_push` out NUM_FIFOS: a push to this queue would be admitted this cycle.
- `count` out NUM_FIFOS*(PTR_WIDTH+1): per-queue occupancy, queue q at bits [q*(PTR_WIDTH+1) +: PTR_WIDTH+1].
- `free_count` out PTR_WIDTH+1: free entries.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- State:
  - data store `mem[DEPTH]` and next-pointer array `nxt[DEPTH]`;
  - per-queue `head`, `tail` and count;
  - free-list head and tail, and `free_count`.
- Reset:
  - free list is 0→1→…→DEPTH-1, `free_count=DEPTH`, all counts 0;
  - `empty` all 1, `full=0`, `can_push` all 1 (or per the rule below);
  - `data_out=0`, `data_out_vld=0`, `overflow=0`, `underflow=0`;
  - all queued data is discarded, including when reset is asserted mid-operation.
- Reserve deficit: `deficit = Σq max(0, RESERVE - count[q])`.
- Admission:
  - If `count[q] < RESERVE`, `can_push[q] = (free_count > 0)`.
  - Otherwise `can_push[q] = (free_count > deficit)`.
  - With `RESERVE=0` this reduces to `~full`.
- Push:
  - Admitted push takes the free-list head, writes `data_in`, and appends the entry to the queue tail.
  - Non-admitted push is dropped, state is unchanged, and `overflow` is set.
- Pop:
  - Pop of a non-empty queue reads the head entry into `data_out` and returns that entry to the free-list tail.
  - Pop of an empty queue is ignored and sets `underflow`.
- Flush:
  - The whole chain of `flush_sel` is spliced onto the free-list tail in one cycle.
  - Its count goes to 0 and `free_count` increases by the old count.
  - Flushing an empty queue is a no-op.
- Simultaneous events:
  - Flush has priority over push and pop to the same queue. Those requests are ignored without setting error flags, and `data_out_vld` stays 0.
  - Push and pop to the same queue both proceed. With count 1, the pushed entry becomes head and tail.
  - Operations on different queues proceed in parallel.
  - Free-list order within a cycle: the push allocation is removed from the head, then the popped entry is appended, then the flushed chain.
  - If the free list is emptied by the allocation, the appended entry becomes the new free head.
- Entries freed in a cycle are not allocatable until the next cycle; admission uses start-of-cycle state.
- Arithmetic: counts are PTR_WIDTH+1 bits and never exceed DEPTH; `free_count + Σcount == DEPTH` always holds.
- `overflow` and `underflow` clear only on reset.

## Timing
- All state updates on the rising edge of `clk`.
- `empty`, `full`, `count`, `free_count` and `can_push` are combinational from registered state and reflect the previous edge.
- Pop latency is 1: `data_out` and `data_out_vld` are valid the cycle after an accepted pop.
- `data_out_vld` is a 1-cycle pulse. `data_out` holds its value when no pop is accepted.
- Error flags assert the cycle after the offending request.
- Push-to-pop through the same queue: earliest pop is the cycle after the push, and data appears one cycle later.

## Test plan
Parameters for all scenarios: `WIDTH=8`, `DEPTH=4`, `NUM_FIFOS=2`, `RESERVE=1`.

1. Reset; push 0x11 then 0x22 to q0; pop q0 twice → `data_out` 0x11 then 0x22, each with `data_out_vld=1` one cycle after its pop; `empty[0]=1` afterwards; `free_count=4`.
2. Push four times to q0 → first three accepted; the fourth is dropped, `overflow=1`, `count[0]=3`, `can_push[0]=0`, `can_push[1]=1`. Then push to q1 → accepted, `full=1`.
3. q0 holds 3 entries, q1 is empty; same cycle flush q0 and push 0xAA to q1 → next cycle `count[0]=0`, `count[1]=1`, `free_count=3`. Three further pushes to q1 → two accepted, third dropped.
4. q1 holds 1 entry (0x55); same cycle pop q1 and push 0x66 to q1 → `data_out=0x55`, `count[1]=1`. Next pop returns 0x66.
5. Pop q1 while empty → `underflow=1`, `data_out_vld=0`, all counts unchanged. Same-cycle flush and pop of q0 → no `data_out_vld`, no `underflow`.
6. Drive `rst=0` with both queues non-empty → next cycle all reset values hold (`free_count=4`, `empty=2'b11`, flags 0). A following pop sets `underflow`.
